// File: rtl/magnitude_stream_reader.sv
// Frame-to-stream adapter for squared-magnitude bins: captures one packed frame,
// streams it bin by bin with valid/ready, then reports the peak bin and its index.
module magnitude_stream_reader #(
    parameter int sample_size = 32,
    parameter int buffer_size = 32,
    localparam int INDEX_WIDTH = (buffer_size > 1) ? $clog2(buffer_size) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [buffer_size*sample_size-1:0] in_mags,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [sample_size-1:0]             out_mag,
    output logic [INDEX_WIDTH-1:0]             out_index,
    output logic                               out_valid,
    output logic                               out_last,
    input  logic                               out_ready,
    output logic [sample_size-1:0]             peak_mag,
    output logic [INDEX_WIDTH-1:0]             peak_index,
    output logic                               peak_valid,
    output logic                               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_REPORT
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(buffer_size - 1);

    state_t                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   index_q, index_d;
    logic [sample_size-1:0]   run_mag_q, run_mag_d;
    logic [INDEX_WIDTH-1:0]   run_idx_q, run_idx_d;
    logic [sample_size-1:0]   peak_mag_q, peak_mag_d;
    logic [INDEX_WIDTH-1:0]   peak_idx_q, peak_idx_d;
    logic                     load_frame;
    logic [sample_size-1:0]   cur_mag;

    logic [sample_size-1:0]   in_bin  [buffer_size];
    logic [sample_size-1:0]   frame_q [buffer_size];

    for (genvar gi = 0; gi < buffer_size; gi++) begin : g_unpack
        assign in_bin[gi] = in_mags[gi*sample_size +: sample_size];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < buffer_size; i++) frame_q[i] <= '0;
        end else if (load_frame) begin
            for (int i = 0; i < buffer_size; i++) frame_q[i] <= in_bin[i];
        end
    end

    assign cur_mag = frame_q[index_q];

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        run_mag_d  = run_mag_q;
        run_idx_d  = run_idx_q;
        peak_mag_d = peak_mag_q;
        peak_idx_d = peak_idx_q;
        load_frame = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    load_frame = 1'b1;
                    index_d    = '0;
                    run_mag_d  = '0;
                    run_idx_d  = '0;
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    // Strictly-greater keeps the lowest index on ties; bin 0 always seeds.
                    if (index_q == '0 || cur_mag > run_mag_q) begin
                        run_mag_d = cur_mag;
                        run_idx_d = index_q;
                    end
                    if (index_q == LAST_IDX) begin
                        peak_mag_d = run_mag_d;
                        peak_idx_d = run_idx_d;
                        state_d    = S_REPORT;
                    end else begin
                        index_d = index_q + INDEX_WIDTH'(1);
                    end
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            run_mag_q  <= '0;
            run_idx_q  <= '0;
            peak_mag_q <= '0;
            peak_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            run_mag_q  <= run_mag_d;
            run_idx_q  <= run_idx_d;
            peak_mag_q <= peak_mag_d;
            peak_idx_q <= peak_idx_d;
        end
    end

    // Stream outputs are forced to zero outside STREAM so idle outputs read as 0.
    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_STREAM);
    assign out_mag    = out_valid ? cur_mag : '0;
    assign out_index  = out_valid ? index_q : '0;
    assign out_last   = out_valid && (index_q == LAST_IDX);
    assign peak_mag   = peak_mag_q;
    assign peak_index = peak_idx_q;
    assign peak_valid = (state_q == S_REPORT);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_magnitude_stream_reader.sv
// Directed bench for magnitude_stream_reader with 4 bins of 16 bits.
module tb_magnitude_stream_reader;

    localparam int S  = 16;
    localparam int B  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [B*S-1:0] in_mags;
    logic           in_valid;
    logic           in_ready;
    logic [S-1:0]   out_mag;
    logic [IW-1:0]  out_index;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;
    logic [S-1:0]   peak_mag;
    logic [IW-1:0]  peak_index;
    logic           peak_valid;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    magnitude_stream_reader #(.sample_size(S), .buffer_size(B)) dut (
        .clk(clk), .reset(reset), .in_mags(in_mags), .in_valid(in_valid),
        .in_ready(in_ready), .out_mag(out_mag), .out_index(out_index),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .peak_mag(peak_mag), .peak_index(peak_index), .peak_valid(peak_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [B*S-1:0] pack4(input logic [S-1:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    // Presents a frame in IDLE and clocks it in; returns positioned on bin 0.
    task automatic accept_frame(input logic [B*S-1:0] f);
        in_mags  = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mags = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, peak_valid, busy, out_last} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags got in_ready/out_valid/peak_valid/busy/out_last=%b expected 10000",
                     {in_ready, out_valid, peak_valid, busy, out_last});
        end
        n_checks++;
        if ({out_mag, out_index, peak_mag, peak_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got out_mag=%h out_index=%0d peak_mag=%h peak_index=%0d expected all 0",
                     out_mag, out_index, peak_mag, peak_index);
        end
    endtask

    task automatic test_basic_stream();
        logic [S-1:0] exp_bins [B];
        exp_bins = '{16'd5, 16'd9, 16'd3, 16'd9};
        out_ready = 1'b1;
        accept_frame(pack4(16'd5, 16'd9, 16'd3, 16'd9));
        for (int k = 0; k < B; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_mag !== exp_bins[k] || out_index !== IW'(k) ||
                out_last !== (k == B-1) || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_beat%0d got valid=%b mag=%0d idx=%0d last=%b in_ready=%b expected valid=1 mag=%0d idx=%0d last=%b in_ready=0",
                         k, out_valid, out_mag, out_index, out_last, in_ready, exp_bins[k], k, (k == B-1));
            end
            tick();
        end
        n_checks++;
        if (peak_valid !== 1'b1 || peak_mag !== 16'd9 || peak_index !== 2'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_peak got pv=%b peak=%0d idx=%0d out_valid=%b expected pv=1 peak=9 idx=1 out_valid=0",
                     peak_valid, peak_mag, peak_index, out_valid);
        end
        tick();
        n_checks++;
        if (peak_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || peak_mag !== 16'd9 || peak_index !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_idle got pv=%b in_ready=%b busy=%b peak=%0d idx=%0d expected pv=0 in_ready=1 busy=0 peak=9 idx=1",
                     peak_valid, in_ready, busy, peak_mag, peak_index);
        end
    endtask

    task automatic test_stall();
        logic [S-1:0] exp_bins [B];
        exp_bins = '{16'd5, 16'd9, 16'd3, 16'd9};
        out_ready = 1'b1;
        accept_frame(pack4(16'd5, 16'd9, 16'd3, 16'd9));
        for (int k = 0; k < B; k++) begin
            if (k == 2) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    n_checks++;
                    if (out_valid !== 1'b1 || out_mag !== 16'd3 || out_index !== 2'd2 || out_last !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_hold%0d got valid=%b mag=%0d idx=%0d last=%b expected valid=1 mag=3 idx=2 last=0",
                                 s, out_valid, out_mag, out_index, out_last);
                    end
                end
                out_ready = 1'b1;
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_mag !== exp_bins[k] || out_index !== IW'(k) || out_last !== (k == B-1)) begin
                n_fail++;
                $display("FAIL stall_beat%0d got valid=%b mag=%0d idx=%0d last=%b expected valid=1 mag=%0d idx=%0d last=%b",
                         k, out_valid, out_mag, out_index, out_last, exp_bins[k], k, (k == B-1));
            end
            tick();
        end
        n_checks++;
        if (peak_valid !== 1'b1 || peak_mag !== 16'd9 || peak_index !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_peak got pv=%b peak=%0d idx=%0d expected pv=1 peak=9 idx=1",
                     peak_valid, peak_mag, peak_index);
        end
        tick();
    endtask

    task automatic test_unsigned_and_last();
        out_ready = 1'b1;
        accept_frame(pack4(16'h8000, 16'h0001, 16'h7FFF, 16'h0000));
        repeat (B) tick();
        n_checks++;
        if (peak_valid !== 1'b1 || peak_mag !== 16'h8000 || peak_index !== 2'd0) begin
            n_fail++;
            $display("FAIL unsigned_peak got pv=%b peak=%h idx=%0d expected pv=1 peak=8000 idx=0",
                     peak_valid, peak_mag, peak_index);
        end
        tick();
        accept_frame(pack4(16'd1, 16'd2, 16'd3, 16'd4));
        repeat (B) tick();
        n_checks++;
        if (peak_valid !== 1'b1 || peak_mag !== 16'd4 || peak_index !== 2'd3) begin
            n_fail++;
            $display("FAIL last_bin_peak got pv=%b peak=%0d idx=%0d expected pv=1 peak=4 idx=3",
                     peak_valid, peak_mag, peak_index);
        end
        tick();
    endtask

    // in_valid stays high with new data every cycle: frames accepted at t=0 and t=6 only.
    task automatic test_back_to_back();
        logic [S-1:0] base;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            base = S'(t) << 8;
            in_mags = pack4(base, base + 16'd1, base + 16'd2, base + 16'd3);
            if (t == 0 || t == 6 || t == 12) begin
                n_checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle_t%0d got in_ready=%b out_valid=%b busy=%b expected 1 0 0",
                             t, in_ready, out_valid, busy);
                end
            end else if (t == 5 || t == 11) begin
                n_checks++;
                if (peak_valid !== 1'b1 || peak_mag !== ((t == 5) ? 16'h0003 : 16'h0603) || peak_index !== 2'd3) begin
                    n_fail++;
                    $display("FAIL b2b_peak_t%0d got pv=%b peak=%h idx=%0d expected pv=1 peak=%h idx=3",
                             t, peak_valid, peak_mag, peak_index, (t == 5) ? 16'h0003 : 16'h0603);
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                    out_mag !== ((t < 6) ? 16'h0000 + S'(t-1) : 16'h0600 + S'(t-7))) begin
                    n_fail++;
                    $display("FAIL b2b_beat_t%0d got valid=%b in_ready=%b mag=%h expected valid=1 in_ready=0 mag=%h",
                             t, out_valid, in_ready, out_mag,
                             (t < 6) ? 16'h0000 + S'(t-1) : 16'h0600 + S'(t-7));
                end
            end
            if (t < 12) tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        accept_frame(pack4(16'd7, 16'd8, 16'd9, 16'd1));
        tick(); tick();
        n_checks++;
        if (out_index !== 2'd2 || out_mag !== 16'd9) begin
            n_fail++;
            $display("FAIL rst_mid_pos got idx=%0d mag=%0d expected idx=2 mag=9", out_index, out_mag);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || peak_valid !== 1'b0 ||
            peak_mag !== 16'd0 || peak_index !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid_state got out_valid=%b in_ready=%b busy=%b pv=%b peak=%h idx=%0d expected 0 1 0 0 0000 0",
                     out_valid, in_ready, busy, peak_valid, peak_mag, peak_index);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (peak_valid !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet%0d got pv=%b out_valid=%b expected 0 0", c, peak_valid, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_stall();
        test_unsigned_and_last();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/magnitude_stream_reader.md
Name: magnitude_stream_reader

Overview:
- Consumer of the FFT partial-magnitude stage.
- Accepts one packed frame of buffer_size squared-magnitude bins (re^2 + im^2) per valid/ready handshake and stores it in an internal frame register.
- Streams the frame out one bin per accepted beat with valid/ready flow control.
- Reports the peak bin and its index after the last beat, for the downstream spectrum display and pitch logic.

Parameters:
- sample_size, 32, width in bits of one magnitude bin.
- buffer_size, 32, bins per frame; must be >= 2.
- INDEX_WIDTH, derived: $clog2(buffer_size), minimum 1; not user-overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_mags  input  buffer_size*sample_size  packed frame; bin k occupies bits [sample_size*k + sample_size-1 : sample_size*k].
- in_valid  input  1  frame on in_mags is valid.
- in_ready  output  1  block can accept a frame.
- out_mag  output  sample_size  current bin value.
- out_index  output  INDEX_WIDTH  bin number of out_mag.
- out_valid  output  1  out_mag and out_index are valid.
- out_last  output  1  current beat is bin buffer_size-1.
- out_ready  input  1  downstream accepts the beat.
- peak_mag  output  sample_size  largest bin of the last completed frame.
- peak_index  output  INDEX_WIDTH  index of peak_mag.
- peak_valid  output  1  one-cycle pulse when peak_mag and peak_index are updated.
- busy  output  1  high in STREAM or REPORT.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State goes to IDLE.
  - All outputs are 0 except in_ready=1.
  - Frame register and running peak are cleared.
  - Reset overrides any handshake in the same cycle. A frame in flight is discarded and no peak_valid is emitted.
- Bin arithmetic:
  - Bins are treated as unsigned for comparison, since wrapped squares are nonnegative by intent.
  - No arithmetic is applied to bin values; they pass through bit-exact.
- IDLE state:
  - in_ready=1, out_valid=0.
  - On in_valid=1: capture in_mags into the frame register, set index=0, clear the running peak, go to STREAM.
  - Latency: a frame accepted at edge N gives out_valid=1 with bin 0 after edge N.
- STREAM state:
  - in_ready=0, out_valid=1.
  - out_mag = frame[index], out_index = index.
  - out_last = (index == buffer_size-1).
  - A beat transfers only when out_valid and out_ready are both 1. While out_ready=0, all out_* values hold stable.
  - On each transfer, the running peak is updated:
    - Bin 0 always loads the peak.
    - Later bins replace it only if strictly greater, so on ties the lowest index wins.
  - On transfer of the last beat, go to REPORT; otherwise index increments.
- REPORT state:
  - Lasts exactly one cycle, out_valid=0.
  - peak_mag and peak_index are loaded from the running peak; peak_valid=1 for this cycle only.
  - Then go to IDLE.
  - peak_mag and peak_index hold their values until the next REPORT or reset.
- Frame spacing: in_ready is low in STREAM and REPORT, so in_valid is ignored there and the frame register never changes mid-frame. The next frame is accepted at the earliest in the IDLE cycle following REPORT.
- Minimum frame period with out_ready always 1: buffer_size + 2 cycles.
- busy = (state != IDLE).

Test Plan:
- B=4, S=16: after reset, check all outputs 0 and in_ready=1 -> out_valid=0, peak_valid=0, busy=0.
- Load frame bins {5, 9, 3, 9} (bin 0 first) with out_ready=1 -> out_mag 5, 9, 3, 9 on 4 consecutive cycles starting the cycle after accept; out_last only on the 4th beat; next cycle peak_valid=1, peak_mag=9, peak_index=1 (tie keeps the lower index).
- Same frame with out_ready low for 3 cycles during bin 2 -> out_mag=3 and out_index=2 held stable; total sequence unchanged; peak unchanged.
- Bins {0x8000, 0x0001, 0x7FFF, 0x0000} -> peak_mag=0x8000, peak_index=0 (unsigned compare).
- in_valid held high continuously with new data every cycle -> only the frame present at each IDLE accept is streamed; frames spaced buffer_size+2 cycles apart.
- Assert reset during bin 2 of a frame -> next cycle IDLE, out_valid=0, in_ready=1, peak_mag=0, no peak_valid pulse.
